// File: rtl/local_velocity.sv
// World-to-body velocity rotation using an iterative CORDIC, one micro-rotation per clock.
// Build option: define LOCAL_VELOCITY_SAT_EN to clamp scaled outputs instead of wrapping.
module local_velocity #(
   parameter int N_WIDTH    = 32,
   parameter int Q_WIDTH    = 15,
   parameter int ITERATIONS = 16
) (
   input  logic               LOCAL_VELOCITY_CLOCK_50,
   input  logic               LOCAL_VELOCITY_RESET_InLow,
   input  logic               LOCAL_VELOCITY_READY_In,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_VX_GLOBAL_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_VY_GLOBAL_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_WZ_GLOBAL_InBus,
   input  logic [N_WIDTH-1:0] LOCAL_VELOCITY_THETA_InBus,
   output logic               LOCAL_VELOCITY_BUSY_Out,
   output logic               LOCAL_VELOCITY_DONE_Out,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_VX_LOCAL_OutBus,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_VY_LOCAL_OutBus,
   output logic [N_WIDTH-1:0] LOCAL_VELOCITY_WZ_LOCAL_OutBus
);

   localparam int XW  = N_WIDTH + 2;
   localparam int PW  = XW + Q_WIDTH + 2;
   localparam int ITW = $clog2(ITERATIONS + 1);

   localparam logic signed [XW-1:0] DEG90  = XW'(90 * (2 ** Q_WIDTH));
   localparam logic signed [XW-1:0] DEG180 = XW'(180 * (2 ** Q_WIDTH));
   localparam logic signed [XW-1:0] DEG360 = XW'(360 * (2 ** Q_WIDTH));

   localparam int K_INT = $rtoi(0.607253 * (2.0 ** Q_WIDTH) + 0.5);
   localparam logic signed [PW-1:0] K = PW'(K_INT);

`ifdef LOCAL_VELOCITY_SAT_EN
   localparam logic signed [PW-1:0] MAXV = PW'($signed({1'b0, {(N_WIDTH-1){1'b1}}}));
   localparam logic signed [PW-1:0] MINV = PW'($signed({1'b1, {(N_WIDTH-1){1'b0}}}));
`endif

   // atan(2^-i) in degrees, Q_WIDTH fraction; Taylor series converges fast for i >= 1
   function automatic int atanDeg(input int i);
      real t, x2, term, sum, den;
      if (i == 0) return 45 * (2 ** Q_WIDTH);
      t = 1.0;
      for (int k = 0; k < i; k++) t = t / 2.0;
      x2   = t * t;
      term = t;
      sum  = 0.0;
      den  = 1.0;
      for (int k = 0; k < 40; k++) begin
         sum  = (k % 2 == 0) ? sum + term / den : sum - term / den;
         term = term * x2;
         den  = den + 2.0;
      end
      return $rtoi(sum * 180.0 / 3.14159265358979 * (2.0 ** Q_WIDTH) + 0.5);
   endfunction

   function automatic logic [N_WIDTH-1:0] fitOut(input logic signed [PW-1:0] v);
`ifdef LOCAL_VELOCITY_SAT_EN
      if (v > MAXV) return {1'b0, {(N_WIDTH-1){1'b1}}};
      if (v < MINV) return {1'b1, {(N_WIDTH-1){1'b0}}};
`endif
      return v[N_WIDTH-1:0];
   endfunction

   logic signed [XW-1:0] atanTable [2**ITW];
   for (genvar g = 0; g < 2**ITW; g++) begin : genAtan
      localparam int A = (g < ITERATIONS) ? atanDeg(g) : 0;
      assign atanTable[g] = XW'(A);
   end

   typedef enum logic [1:0] {StIdle, StReduce, StRotate, StScale} state_e;

   state_e               stateQ, stateD;
   logic signed [XW-1:0] xQ, xD, yQ, yD, zQ, zD;
   logic [ITW-1:0]       iterQ, iterD;
   logic [N_WIDTH-1:0]   wzQ, wzD;
   logic [N_WIDTH-1:0]   vxOutQ, vxOutD, vyOutQ, vyOutD, wzOutQ, wzOutD;
   logic                 doneQ, doneD;
   logic signed [XW-1:0] zr, xs, ys;

   always_ff @(posedge LOCAL_VELOCITY_CLOCK_50 or negedge LOCAL_VELOCITY_RESET_InLow) begin
      if (!LOCAL_VELOCITY_RESET_InLow) begin
         stateQ <= StIdle;
         xQ     <= '0;
         yQ     <= '0;
         zQ     <= '0;
         iterQ  <= '0;
         wzQ    <= '0;
         vxOutQ <= '0;
         vyOutQ <= '0;
         wzOutQ <= '0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         xQ     <= xD;
         yQ     <= yD;
         zQ     <= zD;
         iterQ  <= iterD;
         wzQ    <= wzD;
         vxOutQ <= vxOutD;
         vyOutQ <= vyOutD;
         wzOutQ <= wzOutD;
         doneQ  <= doneD;
      end
   end

   always_comb begin
      stateD = stateQ;
      xD     = xQ;
      yD     = yQ;
      zD     = zQ;
      iterD  = iterQ;
      wzD    = wzQ;
      vxOutD = vxOutQ;
      vyOutD = vyOutQ;
      wzOutD = wzOutQ;
      doneD  = 1'b0;
      zr     = '0;
      xs     = '0;
      ys     = '0;
      unique case (stateQ)
         StIdle: begin
            if (LOCAL_VELOCITY_READY_In) begin
               xD     = XW'($signed(LOCAL_VELOCITY_VX_GLOBAL_InBus));
               yD     = XW'($signed(LOCAL_VELOCITY_VY_GLOBAL_InBus));
               zD     = XW'($signed(LOCAL_VELOCITY_THETA_InBus));
               wzD    = LOCAL_VELOCITY_WZ_GLOBAL_InBus;
               stateD = StReduce;
            end
         end
         StReduce: begin
            // Bring -theta into [-90, 90]; a half-turn is folded in by negating x and y
            zr = -zQ;
            if (zr >= DEG180) zr = zr - DEG360;
            else if (zr < -DEG180) zr = zr + DEG360;
            if (zr > DEG90) begin
               xD = -xQ;
               yD = -yQ;
               zr = zr - DEG180;
            end else if (zr < -DEG90) begin
               xD = -xQ;
               yD = -yQ;
               zr = zr + DEG180;
            end
            zD     = zr;
            iterD  = '0;
            stateD = StRotate;
         end
         StRotate: begin
            xs = xQ >>> iterQ;
            ys = yQ >>> iterQ;
            if (!zQ[XW-1]) begin
               xD = xQ - ys;
               yD = yQ + xs;
               zD = zQ - atanTable[iterQ];
            end else begin
               xD = xQ + ys;
               yD = yQ - xs;
               zD = zQ + atanTable[iterQ];
            end
            iterD = iterQ + 1'b1;
            if (iterQ == ITW'(ITERATIONS - 1)) stateD = StScale;
         end
         StScale: begin
            vxOutD = fitOut((PW'(xQ) * K) >>> Q_WIDTH);
            vyOutD = fitOut((PW'(yQ) * K) >>> Q_WIDTH);
            wzOutD = wzQ;
            doneD  = 1'b1;
            stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   assign LOCAL_VELOCITY_BUSY_Out        = (stateQ != StIdle);
   assign LOCAL_VELOCITY_DONE_Out        = doneQ;
   assign LOCAL_VELOCITY_VX_LOCAL_OutBus = vxOutQ;
   assign LOCAL_VELOCITY_VY_LOCAL_OutBus = vyOutQ;
   assign LOCAL_VELOCITY_WZ_LOCAL_OutBus = wzOutQ;

endmodule

// File: tb/tb_local_velocity.sv
// Directed and randomized bench for local_velocity against an ideal trigonometric model.
module tb_local_velocity;

   localparam real PI = 3.14159265358979;

   logic        clk;
   logic        rstN;
   logic        readyIn;
   logic [31:0] vxIn, vyIn, wzIn, thIn;
   logic        busy, done;
   logic [31:0] vxOut, vyOut, wzOut;

   int vectors = 0;
   int miscompares = 0;

   local_velocity dut (
      .LOCAL_VELOCITY_CLOCK_50        (clk),
      .LOCAL_VELOCITY_RESET_InLow     (rstN),
      .LOCAL_VELOCITY_READY_In        (readyIn),
      .LOCAL_VELOCITY_VX_GLOBAL_InBus (vxIn),
      .LOCAL_VELOCITY_VY_GLOBAL_InBus (vyIn),
      .LOCAL_VELOCITY_WZ_GLOBAL_InBus (wzIn),
      .LOCAL_VELOCITY_THETA_InBus     (thIn),
      .LOCAL_VELOCITY_BUSY_Out        (busy),
      .LOCAL_VELOCITY_DONE_Out        (done),
      .LOCAL_VELOCITY_VX_LOCAL_OutBus (vxOut),
      .LOCAL_VELOCITY_VY_LOCAL_OutBus (vyOut),
      .LOCAL_VELOCITY_WZ_LOCAL_OutBus (wzOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp,
                        input longint tol);
      longint diff;
      vectors++;
      diff = obs - exp;
      if (diff < 0) diff = -diff;
      assert (diff <= tol) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic longint rnd(input real v);
      return longint'($floor(v + 0.5));
   endfunction

   function automatic longint sx(input logic [31:0] v);
      return longint'($signed(v));
   endfunction

   // Drives one request (called #1 after an edge), then checks latency and results
   task automatic runOp(input int vx, input int vy, input int wz, input int th,
                        input bit chkVals, input string tag);
      real    r;
      longint ex, ey;
      int     n;
      bit     seen;
      r  = real'(th) / 32768.0 * PI / 180.0;
      ex = rnd(real'(vx) * $cos(r) + real'(vy) * $sin(r));
      ey = rnd(-real'(vx) * $sin(r) + real'(vy) * $cos(r));
      vxIn = vx;
      vyIn = vy;
      wzIn = wz;
      thIn = th;
      readyIn = 1'b1;
      @(posedge clk);
      #1;
      readyIn = 1'b0;
      check({tag, "_busy"}, longint'(busy), 1, 0);
      n = 1;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         seen = done;
      end
      check({tag, "_latency"}, n, 19, 0);
      check({tag, "_busy_at_done"}, longint'(busy), 0, 0);
      check({tag, "_wz"}, sx(wzOut), longint'(wz), 0);
      if (chkVals) begin
         check({tag, "_vx"}, sx(vxOut), ex, 16);
         check({tag, "_vy"}, sx(vyOut), ey, 16);
      end
   endtask

   initial begin
      int  doneCount, firstDone;
      int  vx, vy, th;
      longint holdVx, holdVy;
      rstN = 1'b0;
      readyIn = 1'b0;
      vxIn = '0;
      vyIn = '0;
      wzIn = '0;
      thIn = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", longint'(busy), 0, 0);
      check("reset_done", longint'(done), 0, 0);
      check("reset_vx", sx(vxOut), 0, 0);
      check("reset_vy", sx(vyOut), 0, 0);
      check("reset_wz", sx(wzOut), 0, 0);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      runOp(32768, 0, 16384, 0, 1'b1, "th0");
      runOp(32768, 0, 16384, 90 * 32768, 1'b1, "th90");
      runOp(32768, 0, -7, -45 * 32768, 1'b1, "thm45");
      runOp(16384, 8192, 100, 180 * 32768, 1'b1, "th180");
      runOp(16384, 8192, 200, -180 * 32768, 1'b1, "thm180");
      runOp(-40000, 50000, 3, 359 * 32768, 1'b1, "th359");
      runOp(131072, -131072, 5, -360 * 32768, 1'b1, "thm360");

      // Outputs must hold while idle even when inputs move
      holdVx = sx(vxOut);
      holdVy = sx(vyOut);
      vxIn = 32'h1234_5678;
      thIn = 32'h0011_0000;
      repeat (4) @(posedge clk);
      #1;
      check("hold_vx", sx(vxOut), holdVx, 0);
      check("hold_vy", sx(vyOut), holdVy, 0);

      // A second READY mid-computation is dropped
      vxIn = 32768;
      vyIn = 0;
      wzIn = 777;
      thIn = 0;
      readyIn = 1'b1;
      @(posedge clk);
      #1;
      readyIn = 1'b0;
      doneCount = 0;
      firstDone = 0;
      for (int e = 2; e <= 45; e++) begin
         if (e == 5) begin
            vxIn = 0;
            vyIn = 32768;
            wzIn = 999;
            thIn = 90 * 32768;
            readyIn = 1'b1;
         end
         @(posedge clk);
         #1;
         readyIn = 1'b0;
         if (done) begin
            doneCount++;
            if (firstDone == 0) firstDone = e;
         end
      end
      check("ignore_done_count", doneCount, 1, 0);
      check("ignore_done_edge", firstDone, 19, 0);
      check("ignore_wz", sx(wzOut), 777, 0);
      check("ignore_vx", sx(vxOut), 32768, 16);

      // READY on the DONE cycle is accepted
      runOp(20000, -10000, 11, 30 * 32768, 1'b1, "b2b_a");
      runOp(-20000, 10000, 12, -120 * 32768, 1'b1, "b2b_b");

      // Reset mid-operation aborts with no DONE
      vxIn = 32768;
      vyIn = 32768;
      wzIn = 555;
      thIn = 10 * 32768;
      readyIn = 1'b1;
      @(posedge clk);
      #1;
      readyIn = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      check("abort_busy", longint'(busy), 0, 0);
      check("abort_vx", sx(vxOut), 0, 0);
      check("abort_vy", sx(vyOut), 0, 0);
      check("abort_wz", sx(wzOut), 0, 0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      doneCount = 0;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk);
         #1;
         if (done) doneCount++;
      end
      check("abort_no_done", doneCount, 0, 0);

      // Out-of-range heading must still complete on time
      runOp(32768, 0, 1, 1000 * 32768, 1'b0, "th_oor");

      for (int k = 0; k < 40; k++) begin
         vx = int'($urandom_range(131072)) - 65536;
         vy = int'($urandom_range(131072)) - 65536;
         th = int'($urandom_range(720 * 32768 - 1)) - 360 * 32768;
         runOp(vx, vy, int'($urandom), th, 1'b1, $sformatf("rand%0d", k));
      end

      runOp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 9, 45 * 32768, 1'b0, "big_pos");
`ifdef LOCAL_VELOCITY_SAT_EN
      check("sat_pos_vx", sx(vxOut), longint'(32'sh7FFF_FFFF), 0);
`else
      check("wrap_pos_sign", longint'(vxOut[31]), 1, 0);
`endif
      runOp(32'h8000_0000, 32'h8000_0000, 9, 45 * 32768, 1'b0, "big_neg");
`ifdef LOCAL_VELOCITY_SAT_EN
      check("sat_neg_vx", sx(vxOut), longint'(32'sh8000_0000), 0);
`else
      check("wrap_neg_sign", longint'(vxOut[31]), 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/local_velocity.md
Name: local_velocity

Overview:
Converts a world-frame (global) velocity vector into the robot body (local) frame. It is the inverse of the global-velocity transform: vx_l = vx_g·cosθ + vy_g·sinθ, vy_l = −vx_g·sinθ + vy_g·cosθ, wz_l = wz_g. The rotation uses an iterative CORDIC (one micro-rotation per clock), so no sin/cos LUT or multiplier array is needed. The block sits between the trajectory/path planner (global commands) and the wheel inverse-kinematics stage.

Parameters:
N_WIDTH, 32, total bit width of all signed fixed-point buses.
Q_WIDTH, 15, fractional bits (Q format) of all buses, including theta in degrees.
ITERATIONS, 16, number of CORDIC micro-rotations (legal range 8..Q_WIDTH+1).

Ports:
LOCAL_VELOCITY_CLOCK_50  in  1  system clock, 50 MHz.
LOCAL_VELOCITY_RESET_InLow  in  1  asynchronous, active-low reset.
LOCAL_VELOCITY_READY_In  in  1  start request; inputs are valid this cycle.
LOCAL_VELOCITY_VX_GLOBAL_InBus  in  N_WIDTH  global vx, m/s, signed Q.
LOCAL_VELOCITY_VY_GLOBAL_InBus  in  N_WIDTH  global vy, m/s, signed Q.
LOCAL_VELOCITY_WZ_GLOBAL_InBus  in  N_WIDTH  global wz, rad/s, signed Q.
LOCAL_VELOCITY_THETA_InBus  in  N_WIDTH  heading in degrees, signed Q; legal range [−360, +360).
LOCAL_VELOCITY_BUSY_Out  out  1  high from the cycle after acceptance until DONE.
LOCAL_VELOCITY_DONE_Out  out  1  one-cycle pulse; the local outputs are valid from this cycle.
LOCAL_VELOCITY_VX_LOCAL_OutBus  out  N_WIDTH  local vx, signed Q.
LOCAL_VELOCITY_VY_LOCAL_OutBus  out  N_WIDTH  local vy, signed Q.
LOCAL_VELOCITY_WZ_LOCAL_OutBus  out  N_WIDTH  local wz (equals global wz), signed Q.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; BUSY=0, DONE=0; all OutBus=0; internal registers cleared.
- States: IDLE → REDUCE → ROTATE → SCALE → IDLE.
- IDLE: READY=1 latches all four inputs and moves to REDUCE. READY in any other state is ignored; no queueing.
- REDUCE (1 clk), angle reduction:
  - z = −θ.
  - If z ≥ 180°, subtract 360°; if z < −180°, add 360°.
  - If z > 90°: negate x and y, then z −= 180°. If z < −90°: negate x and y, then z += 180°.
- ROTATE (ITERATIONS clks), iteration counter i = 0..ITERATIONS−1:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y>>>i); y ← y + d·(x>>>i), both using the old x and y.
  - z ← z − d·atan_deg(2^−i). The atan table is in degrees, Q_WIDTH fraction, built from parameters (entry 0 = 45·2^Q).
  - x and y are internal, N_WIDTH+2 bits wide (growth guard).
- SCALE (1 clk):
  - Multiply x and y by K = round(0.607253·2^Q) (19898 for Q=15), then arithmetic shift right by Q.
  - Register the results to VX/VY OutBus and the latched wz to WZ OutBus.
  - Pulse DONE for 1 clk; BUSY=0; return to IDLE.
- Latency: DONE is high after exactly ITERATIONS+3 rising edges, counting the edge that samples READY as edge 1 (19 by default).
- Back-to-back: READY is honoured in the same cycle DONE is high, because the block is already in IDLE.
- Outputs hold their values until the next DONE.
- Accuracy: within ±16 LSB of the ideal value for |input| ≤ 4.0 with the default parameters.
- Reset mid-operation aborts the computation immediately; no DONE is produced and the outputs return to 0.
- θ outside [−360, +360) gives an undefined result but must not hang the FSM.

Optional Feature:
LOCAL_VELOCITY_SAT_EN
- Defined: SCALE results exceeding the signed N_WIDTH range clamp to 0x7FFF_FFFF / 0x8000_0000 (for N=32).
- Undefined: results are truncated to the low N_WIDTH bits (two's-complement wrap).
- Latency is identical in both builds.

Test Plan:
- vx=1.0 (32768), vy=0, wz=0.5 (16384), θ=0 → after 19 clks DONE=1; vx_l≈32768, vy_l≈0, wz_l=16384 (±16 LSB).
- vx=1.0, vy=0, θ=90° (2949120) → vx_l≈0, vy_l≈−32768 (±16).
- vx=1.0, vy=0, θ=−45° (−1474560) → vx_l≈23170, vy_l≈+23170 (±16).
- vx=0.5, vy=0.25, θ=180° → vx_l≈−16384, vy_l≈−8192; repeat with θ=−180° and θ=540°−360°=180° for the same result.
- READY pulsed again at cycle 5 of a computation → ignored; exactly one DONE at cycle 19. READY on the DONE cycle → second DONE 19 clks later.
- Reset low at cycle 10 of a computation → outputs=0, BUSY=0, no DONE. With SAT_EN and vx=vy=0x7FFF_FFFF, θ=45° → vx_l=0x7FFF_FFFF.
